// File: rtl/dds_pkg.sv
// Shared types and default sizing for the DDS waveform player.
// Macro defaults apply only when the build does not override them.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef DATA_DEPTH
`define DATA_DEPTH 256
`endif

package dds_pkg;

  localparam int unsigned PhaseWDefault = 32;
  localparam int unsigned RdLatDefault  = 2;
  localparam int unsigned ADDR_W        = $clog2(`DATA_DEPTH);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain
  } dds_state_e;

endpackage

// File: rtl/dds_lat_pipe.sv
// Valid tracker: delays an issue strobe by Depth cycles to line up with RAM read data.
module dds_lat_pipe #(
  parameter int unsigned Depth = 2
) (
  input  logic clk_i,
  input  logic clear_i,
  input  logic valid_i,
  output logic valid_o
);

  if (Depth == 0) begin : g_bypass
    assign valid_o = valid_i;
  end else begin : g_pipe
    logic [Depth-1:0] pipe_q;

    always_ff @(posedge clk_i) begin
      if (clear_i) begin
        pipe_q <= '0;
      end else begin
        pipe_q[0] <= valid_i;
        for (int i = 1; i < Depth; i++) begin
          pipe_q[i] <= pipe_q[i-1];
        end
      end
    end

    assign valid_o = pipe_q[Depth-1];
  end

endmodule

// File: rtl/dds_player.sv
// Direct digital synthesis player: walks a phase accumulator over an external
// waveform RAM and emits one registered sample per issued read.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef DATA_DEPTH
`define DATA_DEPTH 256
`endif

module dds_player
  import dds_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = `DATA_WIDTH,
  parameter int unsigned DATA_DEPTH = `DATA_DEPTH,
  parameter int unsigned PHASE_W    = PhaseWDefault,
  parameter int unsigned RD_LAT     = RdLatDefault,
  localparam int unsigned AddrW     = $clog2(DATA_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  ftw_load,
  input  logic [PHASE_W-1:0]    ftw,
  input  logic [AddrW-1:0]      pha_off,
  output logic [AddrW-1:0]      r_addr,
  input  logic [DATA_WIDTH-1:0] r_data,
  output logic [DATA_WIDTH-1:0] sample,
  output logic                  sample_valid,
  output logic                  busy,
  output logic                  wrap
);

  localparam int unsigned CntW = $clog2(RD_LAT + 2);

  dds_state_e state_q, state_d;
  logic [PHASE_W-1:0]    phase_q, phase_d;
  logic [PHASE_W-1:0]    ftw_q, ftw_d;
  logic [CntW-1:0]       drain_cnt_q, drain_cnt_d;
  logic                  wrap_q, wrap_d;
  logic [DATA_WIDTH-1:0] sample_q;
  logic                  sample_valid_q;
  logic                  issue;
  logic                  tail_valid;
  logic [PHASE_W:0]      acc;

  // Extra top bit captures the accumulator carry for the wrap pulse.
  assign acc = {1'b0, phase_q} + {1'b0, ftw_q};

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    ftw_d       = ftw_q;
    drain_cnt_d = drain_cnt_q;
    wrap_d      = 1'b0;
    issue       = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRun;
          phase_d = '0;
          ftw_d   = ftw;
        end
      end
      StRun: begin
        issue   = 1'b1;
        phase_d = acc[PHASE_W-1:0];
        wrap_d  = acc[PHASE_W];
        if (ftw_load) begin
          ftw_d = ftw;
        end
        if (stop) begin
          state_d     = StDrain;
          drain_cnt_d = '0;
        end
      end
      StDrain: begin
        // Hold off IDLE until the last issued read has surfaced as a sample.
        if (drain_cnt_q == CntW'(RD_LAT)) begin
          state_d = StIdle;
        end else begin
          drain_cnt_d = drain_cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      phase_q     <= '0;
      ftw_q       <= '0;
      drain_cnt_q <= '0;
      wrap_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      ftw_q       <= ftw_d;
      drain_cnt_q <= drain_cnt_d;
      wrap_q      <= wrap_d;
    end
  end

  dds_lat_pipe #(
    .Depth (RD_LAT)
  ) u_lat_pipe (
    .clk_i   (clk),
    .clear_i (~rst_n),
    .valid_i (issue),
    .valid_o (tail_valid)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
    end else if (tail_valid) begin
      sample_q       <= r_data;
      sample_valid_q <= 1'b1;
    end else begin
      sample_valid_q <= 1'b0;
    end
  end

  assign r_addr       = phase_q[PHASE_W-1 -: AddrW] + pha_off;
  assign sample       = sample_q;
  assign sample_valid = sample_valid_q;
  assign busy         = (state_q != StIdle);
  assign wrap         = wrap_q;

endmodule

// File: tb/tb_dds_player.sv
// Directed and randomized checks of dds_player against a phase-sum reference
// model, with a behavioural RAM of matching read latency.
module tb_dds_player;

  localparam int unsigned DW = 8;
  localparam int unsigned DD = 256;
  localparam int unsigned PW = 32;
  localparam int unsigned RL = 2;
  localparam int unsigned AW = 8;
  localparam longint unsigned Mod = 64'h1_0000_0000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, stop, ftw_load;
  logic [PW-1:0] ftw;
  logic [AW-1:0] pha_off;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_data;
  logic [DW-1:0] sample;
  logic          sample_valid, busy, wrap;

  logic [DW-1:0] mem [DD];
  logic [DW-1:0] rd1, rd2;

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;

  logic [DW-1:0] gotv [$];
  int            gotc [$];
  int            wrapc [$];

  dds_player #(
    .DATA_WIDTH (DW),
    .DATA_DEPTH (DD),
    .PHASE_W    (PW),
    .RD_LAT     (RL)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .stop         (stop),
    .ftw_load     (ftw_load),
    .ftw          (ftw),
    .pha_off      (pha_off),
    .r_addr       (r_addr),
    .r_data       (r_data),
    .sample       (sample),
    .sample_valid (sample_valid),
    .busy         (busy),
    .wrap         (wrap)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    rd1 <= mem[r_addr];
    rd2 <= rd1;
  end
  assign r_data = rd2;

  always @(negedge clk) begin
    if (sample_valid === 1'b1) begin
      gotv.push_back(sample);
      gotc.push_back(cyc);
    end
    if (wrap === 1'b1) wrapc.push_back(cyc);
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Plays nreads reads; ftw_load of f2 lands on read index load_at.
  task automatic play(input logic [PW-1:0] f, input logic [AW-1:0] off, input int nreads,
                      input int load_at, input logic [PW-1:0] f2, input bit noise,
                      input bit start_drain);
    longint unsigned p, fc;
    logic [63:0] ea [$];
    int ew [$];
    int s, d, fall;
    s = cyc;
    p = 0;
    fc = 64'(f);
    for (int n = 0; n < nreads; n++) begin
      ea.push_back(((p >> (PW - AW)) + 64'(off)) % DD);
      if (p + fc >= Mod) ew.push_back(s + n + 2);
      p = (p + fc) % Mod;
      if (n == load_at) fc = 64'(f2);
    end
    gotv.delete();
    gotc.delete();
    wrapc.delete();
    ftw = f;
    pha_off = off;
    start = 1'b1;
    step();
    for (int n = 0; n < nreads; n++) begin
      chk("run_busy", 64'(busy), 64'd1);
      chk("r_addr", 64'(r_addr), ea[n]);
      ftw_load = (n == load_at);
      if (n == load_at) ftw = f2;
      stop = (n == nreads - 1);
      start = noise ? 1'($urandom % 2) : 1'b0;
      step();
    end
    ftw_load = 1'b0;
    stop = 1'b0;
    start = 1'b0;
    d = cyc;
    fall = -1;
    for (int i = 0; i < 20 && fall < 0; i++) begin
      if (!busy) begin
        fall = cyc;
      end else begin
        start = (i == 1) && start_drain;
        step();
      end
    end
    start = 1'b0;
    chk("busy_fall", 64'(fall - d), 64'(RL + 1));
    repeat (4) step();
    chk("idle_after_drain", 64'(busy), 64'd0);
    chk("sample_count", 64'(gotv.size()), 64'(nreads));
    if (gotc.size() > 0) chk("first_valid_lat", 64'(gotc[0] - s), 64'(RL + 2));
    for (int k = 0; k < nreads && k < gotv.size(); k++) begin
      chk("sample_val", 64'(gotv[k]), 64'(mem[int'(ea[k])]));
      chk("sample_cyc", 64'(gotc[k]), 64'(s + k + RL + 2));
    end
    chk("wrap_count", 64'(wrapc.size()), 64'(ew.size()));
    for (int k = 0; k < ew.size() && k < wrapc.size(); k++) begin
      chk("wrap_cyc", 64'(wrapc[k]), 64'(ew[k]));
    end
  endtask

  initial begin
    int s;
    for (int i = 0; i < DD; i++) mem[i] = DW'(i);
    rst_n = 1'b0;
    start = 1'b0;
    stop = 1'b0;
    ftw_load = 1'b0;
    ftw = '0;
    pha_off = '0;
    step();
    step();
    chk("rst_sample", 64'(sample), 64'd0);
    chk("rst_valid", 64'(sample_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_wrap", 64'(wrap), 64'd0);
    rst_n = 1'b1;
    step();

    // Full sweep of the table plus turnover back to 0.
    play(32'h0100_0000, 8'd0, 257, -1, '0, 1'b0, 1'b0);
    // Double step with offset.
    play(32'h0200_0000, 8'd10, 20, -1, '0, 1'b0, 1'b0);
    // Zero tuning word: constant address and sample, no wrap.
    play(32'h0, 8'($urandom), 20, -1, '0, 1'b0, 1'b0);
    // Early stop with a start pulse inside DRAIN.
    play(32'h0100_0000, 8'd3, 5, -1, '0, 1'b0, 1'b1);
    // Tuning word doubled mid-run.
    play(32'h0100_0000, 8'd0, 20, 8, 32'h0200_0000, 1'b0, 1'b0);

    // start and stop together in IDLE: start wins.
    start = 1'b1;
    stop = 1'b1;
    step();
    start = 1'b0;
    stop = 1'b0;
    chk("start_beats_stop", 64'(busy), 64'd1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    repeat (6) step();
    chk("idle_after_stop", 64'(busy), 64'd0);

    // Reset mid-RUN discards in-flight reads.
    gotv.delete();
    gotc.delete();
    wrapc.delete();
    s = cyc;
    ftw = 32'h0100_0000;
    pha_off = '0;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (5) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("midrst_sample", 64'(sample), 64'd0);
    chk("midrst_valid", 64'(sample_valid), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_wrap", 64'(wrap), 64'd0);
    repeat (6) step();
    chk("midrst_count", 64'(gotv.size()), 64'd3);
    chk("midrst_last_cyc", 64'(gotc.size() > 0 ? gotc[gotc.size()-1] : -1), 64'(s + 6));

    // Randomized runs over random table contents.
    for (int i = 0; i < DD; i++) mem[i] = DW'($urandom);
    for (int r = 0; r < 8; r++) begin
      int nr;
      nr = int'($urandom_range(1, 40));
      play($urandom, 8'($urandom), nr, int'($urandom_range(0, 40)), $urandom, 1'b1,
           1'($urandom % 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/dds_player.md
DDS_PLAYER -- requirements
Module: dds_player

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default `DATA_WIDTH (8): width of each waveform sample.
REQ-002 SHALL have parameter DATA_DEPTH, default `DATA_DEPTH (256): RAM table depth, a power of two; ADDR_W = $clog2(DATA_DEPTH).
REQ-003 SHALL have parameter PHASE_W, default 32: phase accumulator width, PHASE_W > ADDR_W.
REQ-004 SHALL have parameter RD_LAT, default 2: RAM read latency in cycles from r_addr to r_data.
REQ-005 SHALL use one clock and a synchronous active-low reset, ports clk and rst_n.
REQ-006 clk  input  1  system clock.
REQ-007 rst_n  input  1  synchronous active-low reset.
REQ-008 start  input  1  one-cycle pulse that begins playback.
REQ-009 stop  input  1  one-cycle pulse that ends playback.
REQ-010 ftw_load  input  1  loads ftw while running.
REQ-011 ftw  input  PHASE_W  frequency tuning word.
REQ-012 pha_off  input  ADDR_W  phase offset added to the table address.
REQ-013 r_addr  output  ADDR_W  read address to the RAM read port.
REQ-014 r_data  input  DATA_WIDTH  read data from the RAM read port.
REQ-015 sample  output  DATA_WIDTH  registered output sample.
REQ-016 sample_valid  output  1  sample is valid in this cycle.
REQ-017 busy  output  1  state is not IDLE.
REQ-018 wrap  output  1  one-cycle pulse on phase accumulator overflow.

Function
REQ-019 SHALL implement the FSM states IDLE, RUN and DRAIN.
REQ-020 IDLE with start=1 SHALL go to RUN, with phase<=0 and ftw_r<=ftw.
REQ-021 In RUN, each cycle SHALL do phase<=phase+ftw_r mod 2^PHASE_W and issue one read.
REQ-022 r_addr SHALL be phase[PHASE_W-1 -: ADDR_W] + pha_off, mod DATA_DEPTH, combinational from the phase register; it holds its last value outside RUN.
REQ-023 In RUN, ftw_load=1 SHALL update ftw_r, effective from the next accumulation.
REQ-024 In RUN, stop=1 SHALL go to DRAIN; no read is issued in the stop cycle's successor.
REQ-025 DRAIN SHALL count RD_LAT+1 cycles and then go to IDLE, so that every read already issued produces its sample.
REQ-026 start in RUN or DRAIN SHALL be ignored; start and stop together in IDLE SHALL have start win; start and stop together in RUN SHALL have stop win.
REQ-027 A valid shift register of depth RD_LAT SHALL track issued reads; when its tail is 1, sample<=r_data and sample_valid<=1 next cycle, otherwise sample_valid<=0 and sample holds.
REQ-028 Latency: an address issued in cycle k SHALL give sample_valid=1 in cycle k+RD_LAT+1.
REQ-029 wrap SHALL be 1 for the cycle after an accumulation whose carry out of bit PHASE_W-1 is 1.
REQ-030 ftw=0 SHALL be legal, producing a constant address and a constant sample stream.

Reset
REQ-031 With rst_n=0 at a clk edge: state=IDLE, phase=0, ftw_r=0, the valid pipeline is cleared, sample=0, sample_valid=0, wrap=0, busy=0.
REQ-032 Reset mid-RUN or mid-DRAIN SHALL discard in-flight reads, and no sample_valid SHALL follow.

Structure
REQ-033 Package dds_pkg SHALL hold the state enum (IDLE/RUN/DRAIN), the PHASE_W and RD_LAT defaults, and ADDR_W derived from `DATA_DEPTH.
REQ-034 The valid/latency tracker SHALL be sub-module dds_lat_pipe (a parameterised RD_LAT shift register with clear).
REQ-035 The read-side RAM SHALL be instantiated outside this block, with clkb tied to clk; RD_LAT matches that RAM.

Verification
REQ-036 Bench: RAM preloaded data[i]=i; ftw=2^(PHASE_W-ADDR_W), pha_off=0, start -> samples 0,1,2,...,255,0; wrap pulse coincides with the 255->0 address turnover; first sample_valid exactly 4 cycles after start sampled (RD_LAT=2).
REQ-037 Bench: ftw=2^(PHASE_W-ADDR_W+1), pha_off=10 -> samples 10,12,14,...
REQ-038 Bench: ftw=0, run 20 cycles -> every sample = data[pha_off], wrap never asserted.
REQ-039 Bench: stop after 5 reads issued -> exactly 5 sample_valid pulses total, busy falls RD_LAT+1 cycles after DRAIN entry, start during DRAIN ignored.
REQ-040 Bench: ftw_load with 2x ftw mid-RUN -> address step doubles from the next cycle onward, with no dropped or duplicated sample.
REQ-041 Bench: rst_n=0 for 1 cycle mid-RUN -> all outputs at reset values next cycle, and no sample_valid for stale reads.
